// File: rtl/tt_i2s_pkg.sv
// rtl/tt_i2s_pkg.sv - shared widths, pin indices and slot-bit helper for the I2S transmitter
package tt_i2s_pkg;

  localparam int SAMPLE_BITS = 8;
  localparam int SLOT_BITS   = 16;
  localparam int FRAME_BITS  = 32;

  localparam int UO_BCLK     = 0;
  localparam int UO_WS       = 1;
  localparam int UO_SDATA    = 2;
  localparam int UO_FRAME    = 3;
  localparam int UO_UNDERRUN = 4;

  localparam int UIO_WR  = 0;
  localparam int UIO_CH  = 1;
  localparam int UIO_CLR = 2;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  // Data lags WS by one BCLK, so position 0 still carries the previous slot's zero padding.
  function automatic logic slot_bit(input logic [SAMPLE_BITS-1:0] sample, input logic [3:0] pos);
    logic [2:0] idx;
    idx = 3'(4'd8 - pos);
    if (pos >= 4'd1 && pos <= 4'd8) return sample[idx];
    else return 1'b0;
  endfunction

endpackage

// File: rtl/i2s_tx_core.sv
// rtl/i2s_tx_core.sv - BCLK divider, frame bit counter, active sample registers and serializer
module i2s_tx_core
  import tt_i2s_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [SAMPLE_BITS-1:0] stage_l,
  input  logic [SAMPLE_BITS-1:0] stage_r,
  output logic                   bclk,
  output logic                   ws,
  output logic                   sdata,
  output logic                   frame_start,
  output logic                   frame_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int POS_W = $clog2(SLOT_BITS);

  logic [DIV_W-1:0]       div;
  logic [CNT_W-1:0]       bitcnt;
  logic [CNT_W-1:0]       bitcnt_nxt;
  logic [SAMPLE_BITS-1:0] act_l;
  logic [SAMPLE_BITS-1:0] act_r;
  logic                   term;
  logic                   fall;

  assign term       = (div == DIV_W'(CLK_DIV - 1));
  assign fall       = ena && term && bclk;
  assign bitcnt_nxt = bitcnt + 1'b1;
  assign frame_tick = fall && (bitcnt_nxt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      bitcnt      <= '0;
      bclk        <= 1'b0;
      ws          <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      act_l       <= '0;
      act_r       <= '0;
    end else if (ena) begin
      div         <= term ? '0 : div + 1'b1;
      frame_start <= frame_tick;
      if (term) bclk <= ~bclk;
      // WS and SDATA move only with BCLK falling so the DAC samples stable data on the rise.
      if (fall) begin
        bitcnt <= bitcnt_nxt;
        ws     <= bitcnt_nxt[CNT_W-1];
        sdata  <= slot_bit(bitcnt_nxt[CNT_W-1] ? act_r : act_l, bitcnt_nxt[POS_W-1:0]);
      end
      if (frame_tick) begin
        act_l <= stage_l;
        act_r <= stage_r;
      end
    end
  end

endmodule

// File: rtl/tt_um_example_i2s.sv
// rtl/tt_um_example_i2s.sv - TinyTapeout I2S top; define UNDERRUN_FLAG_EN for the sticky underrun flag
module tt_um_example_i2s
  import tt_i2s_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic                   wr_prev;
  logic                   wr;
  chan_t                  ch;
  logic [SAMPLE_BITS-1:0] stage_l;
  logic [SAMPLE_BITS-1:0] stage_r;
  logic                   bclk;
  logic                   ws;
  logic                   sdata;
  logic                   frame_start;
  logic                   frame_tick;
  logic                   underrun;
  logic                   unused_pins;

  assign ch = chan_t'(uio_in[UIO_CH]);
  assign wr = uio_in[UIO_WR] && !wr_prev;

  // rst_n is active-high here; the pad-ring name is kept for the wrapper.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_prev <= 1'b0;
      stage_l <= '0;
      stage_r <= '0;
    end else if (ena) begin
      wr_prev <= uio_in[UIO_WR];
      if (wr) begin
        if (ch == CH_RIGHT) stage_r <= ui_in;
        else                stage_l <= ui_in;
      end
    end
  end

`ifdef UNDERRUN_FLAG_EN
  logic seen_l;
  logic seen_r;

  // A write landing on the frame-start edge counts toward the following frame.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      seen_l   <= 1'b0;
      seen_r   <= 1'b0;
      underrun <= 1'b0;
    end else if (ena) begin
      if (frame_tick) begin
        seen_l <= wr && (ch == CH_LEFT);
        seen_r <= wr && (ch == CH_RIGHT);
      end else begin
        if (wr && ch == CH_LEFT)  seen_l <= 1'b1;
        if (wr && ch == CH_RIGHT) seen_r <= 1'b1;
      end
      if (uio_in[UIO_CLR])                       underrun <= 1'b0;
      else if (frame_tick && !(seen_l && seen_r)) underrun <= 1'b1;
    end
  end

  assign unused_pins = &{1'b0, uio_in[7:3]};
`else
  assign underrun    = 1'b0;
  assign unused_pins = &{1'b0, uio_in[7:3], uio_in[UIO_CLR], frame_tick};
`endif

  i2s_tx_core #(
    .CLK_DIV(CLK_DIV)
  ) u_core (
    .clk        (clk),
    .rst        (rst_n),
    .ena        (ena),
    .stage_l    (stage_l),
    .stage_r    (stage_r),
    .bclk       (bclk),
    .ws         (ws),
    .sdata      (sdata),
    .frame_start(frame_start),
    .frame_tick (frame_tick)
  );

  always_comb begin
    uo_out              = '0;
    uo_out[UO_BCLK]     = bclk;
    uo_out[UO_WS]       = ws;
    uo_out[UO_SDATA]    = sdata;
    uo_out[UO_FRAME]    = frame_start;
    uo_out[UO_UNDERRUN] = underrun;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_example_i2s.sv
// tb/tb_tt_um_example_i2s.sv - self-checking bench with a frame-level I2S reference model
module tb_tt_um_example_i2s;

`ifdef UNDERRUN_FLAG_EN
  localparam bit FLAG_ON = 1'b1;
`else
  localparam bit FLAG_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] rx_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  sl = 8'h00;
  logic [7:0]  sr = 8'h00;
  bit          seen_l = 1'b0;
  bit          seen_r = 1'b0;
  bit          mflag = 1'b0;

  tt_um_example_i2s #(.CLK_DIV(2)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failed %0d of %0d", fails, tests);
    $fatal(1, "watchdog");
  end

  // Stream capture: one 32-bit word per frame, bit p sampled on the p-th BCLK rise.
  bit          mon_on = 1'b0;
  int          idx = 0;
  logic [31:0] raw = '0;
  logic        pb = 1'b0, pw = 1'b0, ps = 1'b0;
  int          ws_bad = 0;
  int          chg_bad = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_on = 1'b0;
      idx = 0;
    end else begin
      if (uo_out[3]) begin
        mon_on = 1'b1;
        idx = 0;
      end
      if (mon_on && !pb && uo_out[0] && idx < 32) begin
        raw[idx] = uo_out[2];
        if (uo_out[1] !== 1'(idx >= 16)) ws_bad++;
        idx++;
        if (idx == 32) rx_q.push_back(raw);
      end
      if ((uo_out[1] !== pw || uo_out[2] !== ps) && !(pb && !uo_out[0])) chg_bad++;
    end
    pb = uo_out[0];
    pw = uo_out[1];
    ps = uo_out[2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Two 16-bit slots {sample, 8'h00} sent MSB first, whole stream delayed by one BCLK.
  function automatic logic [31:0] frame_word(input logic [15:0] lr);
    logic [31:0] seq;
    logic [31:0] w;
    seq = {lr[15:8], 8'h00, lr[7:0], 8'h00};
    w = '0;
    for (int p = 1; p < 32; p++) w[p] = seq[32 - p];
    return w;
  endfunction

  task automatic frame_edge();
    exp_q.push_back({sl, sr});
    if (!(seen_l && seen_r)) mflag = 1'b1;
    seen_l = 1'b0;
    seen_r = 1'b0;
    check("underrun_at_frame", {31'b0, uo_out[4]}, {31'b0, mflag & FLAG_ON});
  endtask

  task automatic wait_pulse();
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (uo_out[3] !== 1'b1 && n < 400);
    check("frame_start_seen", {31'b0, uo_out[3]}, 32'd1);
    frame_edge();
  endtask

  task automatic write_byte(input logic ch, input logic [7:0] val);
    uio_in[1] = ch;
    ui_in = val;
    uio_in[0] = 1'b1;
    tick(1);
    uio_in[0] = 1'b0;
    tick(1);
    if (ch) begin
      sr = val;
      seen_r = 1'b1;
    end else begin
      sl = val;
      seen_l = 1'b1;
    end
  endtask

  task automatic clear_flag();
    uio_in[2] = 1'b1;
    tick(1);
    uio_in[2] = 1'b0;
    mflag = 1'b0;
    check("flag_clear", {31'b0, uo_out[4]}, 32'd0);
  endtask

  initial begin
    int n, m, rel, c0, wsh, pul, changes;
    logic [2:0] snap;

    tick(2);
    rst_n = 1'b0;
    rel = cyc;
    check("reset_uo_out", {24'b0, uo_out}, 32'h00);
    check("reset_uio_out", {24'b0, uio_out}, 32'h00);
    check("reset_uio_oe", {24'b0, uio_oe}, 32'h00);

    n = 0;
    do begin tick(1); n++; end while (uo_out[0] !== 1'b1 && n < 20);
    check("first_bclk_rise", n, 2);
    m = 0;
    do begin tick(1); m++; end while (uo_out[0] !== 1'b0 && m < 20);
    do begin tick(1); m++; end while (uo_out[0] !== 1'b1 && m < 40);
    check("bclk_period", m, 4);

    wait_pulse();
    check("first_frame_start_cycle", cyc - rel, 128);

    wsh = 0;
    pul = 0;
    for (int i = 0; i < 128; i++) begin
      tick(1);
      if (uo_out[1]) wsh++;
      if (uo_out[3]) pul++;
    end
    check("ws_high_clks", wsh, 64);
    check("pulses_per_frame", pul, 1);
    check("frame_start_at_128", {31'b0, uo_out[3]}, 32'd1);
    frame_edge();

    tick(10);
    write_byte(1'b0, 8'hA5);
    write_byte(1'b1, 8'h3C);
    clear_flag();
    wait_pulse();

    for (int f = 0; f < 6; f++) begin
      tick(10);
      if ($urandom_range(3) != 0) write_byte(1'b0, 8'($urandom));
      if ($urandom_range(3) != 0) write_byte(1'b1, 8'($urandom));
      if ($urandom_range(1) != 0) clear_flag();
      wait_pulse();
    end

    // Strobe edge sampled on the very edge that starts the next frame.
    tick(127);
    ui_in = 8'h7F;
    uio_in[1] = 1'b0;
    uio_in[0] = 1'b1;
    tick(1);
    check("frame_start_with_write", {31'b0, uo_out[3]}, 32'd1);
    frame_edge();
    sl = 8'h7F;
    seen_l = 1'b1;
    uio_in[0] = 1'b0;
    tick(10);
    write_byte(1'b1, 8'($urandom));
    wait_pulse();

    c0 = cyc;
    tick(40);
    snap = uo_out[2:0];
    ena = 1'b0;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        ui_in = 8'hEE;
        uio_in[1] = 1'b0;
        uio_in[0] = 1'b1;
      end
      if (i == 10) uio_in[0] = 1'b0;
      tick(1);
      if (uo_out[2:0] !== snap) changes++;
    end
    ena = 1'b1;
    check("ena_freeze_outputs", changes, 0);
    wait_pulse();
    check("frame_len_with_freeze", cyc - c0, 148);
    tick(10);
    write_byte(1'b0, 8'($urandom));
    write_byte(1'b1, 8'($urandom));
    wait_pulse();

    check("rx_frame_count", rx_q.size(), exp_q.size() - 1);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check($sformatf("frame%0d_stream", i), rx_q[i], frame_word(exp_q[i]));
    if (rx_q.size() > 2) check("slot_a5_3c_literal", rx_q[2], 32'h0078014A);
    check("ws_slot_alignment", ws_bad, 0);
    check("change_only_on_bclk_fall", chg_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
